// File: rtl/bowling_pkg.sv
// Shared bowling constants, FSM encoding and pin clamp helper.
// Used by the hit sequencer and the downstream score counter.
package bowling_pkg;

  localparam int PINS_W  = 4;
  localparam int SCORE_W = 5;

  localparam logic [PINS_W-1:0]  MAX_PINS   = 4'd10;
  localparam logic [1:0]         MAX_THROWS = 2'd3;
  localparam logic [SCORE_W-1:0] MAX_SCORE  = 5'd30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic [PINS_W-1:0] clamp_pins(
    input logic [PINS_W-1:0] p,
    input logic [PINS_W-1:0] lim
  );
    return (p > lim) ? lim : p;
  endfunction

endpackage

// File: rtl/gap_timer.sv
// Loadable down-counter; done_o marks the last cycle of a gap.
// Ports: CLOCK_50, reset (sync, high), load_i, val_i, done_o.
module gap_timer #(
  parameter int W = 4
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  // A count of 1 means this is the final low cycle.
  assign done_o = (cnt_q <= W'(1));

endmodule

// File: rtl/throw_hit_sequencer.sv
// Turns one accepted throw into spaced one-cycle hit pulses.
// Ports: CLOCK_50, reset, pins_valid/pins/pins_ready in; hit, throw_num, busy, game_over out.
module throw_hit_sequencer
  import bowling_pkg::*;
#(
  parameter logic [PINS_W-1:0] MAX_PINS   = bowling_pkg::MAX_PINS,
  parameter logic [1:0]        MAX_THROWS = bowling_pkg::MAX_THROWS,
  parameter logic [3:0]        GAP_CYCLES = 4'd1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              pins_valid,
  input  logic [PINS_W-1:0] pins,
  output logic              pins_ready,
  output logic              hit,
  output logic [1:0]        throw_num,
  output logic              busy,
  output logic              game_over
);

  state_e            state_q;
  logic [PINS_W-1:0] rem_q;
  logic              hit_q;
  logic              busy_q;
  logic              over_q;
  logic [1:0]        thr_q;
  logic [1:0]        thr_d;
  logic [PINS_W-1:0] clamped;
  logic              accept;
  logic              gap_done;

  assign pins_ready = (state_q == IDLE) && !over_q;
  assign accept     = pins_valid && pins_ready;
  assign clamped    = clamp_pins(pins, MAX_PINS);
  assign thr_d      = (thr_q == MAX_THROWS) ? thr_q : thr_q + 2'd1;

  gap_timer #(.W(4)) u_gap (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .load_i   (state_q == EMIT),
    .val_i    (GAP_CYCLES),
    .done_o   (gap_done)
  );

  // Outputs are registered with the next state, so hit
  // is high exactly during the EMIT cycle.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      hit_q   <= 1'b0;
      busy_q  <= 1'b0;
      over_q  <= 1'b0;
      thr_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            busy_q <= 1'b1;
            rem_q  <= clamped;
            if (clamped != '0) begin
              state_q <= EMIT;
              hit_q   <= 1'b1;
            end else begin
              state_q <= DONE;
            end
          end
        end
        EMIT: begin
          hit_q   <= 1'b0;
          rem_q   <= rem_q - PINS_W'(1);
          state_q <= GAP;
        end
        GAP: begin
          if (gap_done) begin
            if (rem_q != '0) begin
              state_q <= EMIT;
              hit_q   <= 1'b1;
            end else begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          thr_q   <= thr_d;
          if (thr_d == MAX_THROWS) begin
            over_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hit       = hit_q;
  assign busy      = busy_q;
  assign throw_num = thr_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_throw_hit_sequencer.sv
// Directed bench for throw_hit_sequencer with a hit-counting score model.
// Each scenario task checks its own hand-computed expectations.
module tb_throw_hit_sequencer;

  logic       CLOCK_50;
  logic       reset;
  logic       pins_valid;
  logic [3:0] pins;
  logic       pins_ready;
  logic       hit;
  logic [1:0] throw_num;
  logic       busy;
  logic       game_over;

  int checks;
  int errors;
  int score;

  throw_hit_sequencer dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .pins_valid (pins_valid),
    .pins       (pins),
    .pins_ready (pins_ready),
    .hit        (hit),
    .throw_num  (throw_num),
    .busy       (busy),
    .game_over  (game_over)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Downstream score counter model shares reset with the DUT.
  always @(posedge CLOCK_50) begin
    if (reset) score <= 0;
    else if (hit) score <= score + 1;
  end

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pins_valid = 1'b0;
    pins = 4'd0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  // Offers one throw, then observes until busy drops.
  task automatic throw_run(input logic [3:0] p, output int pulses,
                           output int adj, output int bcyc);
    int prev;
    pulses = 0;
    adj = 0;
    bcyc = 0;
    prev = 0;
    pins = p;
    pins_valid = 1'b1;
    step();
    pins_valid = 1'b0;
    while (busy && bcyc < 64) begin
      if (hit) begin
        pulses++;
        if (prev != 0) adj++;
      end
      prev = int'(hit);
      bcyc++;
      step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({hit, busy, throw_num, game_over, pins_ready} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_state: got h=%b b=%b t=%0d g=%b r=%b want 0 0 0 0 1",
               hit, busy, throw_num, game_over, pins_ready);
    end
  endtask

  task automatic test_seven();
    logic eh, eb;
    pins = 4'd7;
    pins_valid = 1'b1;
    step();
    pins_valid = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      eh = (c % 2 == 1) && (c <= 13);
      eb = (c <= 15);
      checks++;
      if (hit !== eh || busy !== eb || pins_ready !== !eb) begin
        errors++;
        $display("FAIL seven_cycle%0d: got h=%b b=%b r=%b want h=%b b=%b r=%b",
                 c, hit, busy, pins_ready, eh, eb, !eb);
      end
      if (c < 16) step();
    end
    checks++;
    if (throw_num !== 2'd1) begin
      errors++;
      $display("FAIL seven_throw_num: got %0d want 1", throw_num);
    end
    checks++;
    if (score !== 7) begin
      errors++;
      $display("FAIL seven_score: got %0d want 7", score);
    end
  endtask

  task automatic test_zero();
    pins = 4'd0;
    pins_valid = 1'b1;
    step();
    pins_valid = 1'b0;
    checks++;
    if (hit !== 1'b0 || busy !== 1'b1 || pins_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: got h=%b b=%b r=%b want 0 1 0",
               hit, busy, pins_ready);
    end
    step();
    checks++;
    if (hit !== 1'b0 || busy !== 1'b0 || pins_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_idle: got h=%b b=%b r=%b want 0 0 1",
               hit, busy, pins_ready);
    end
    checks++;
    if (throw_num !== 2'd2 || score !== 7) begin
      errors++;
      $display("FAIL zero_count: got t=%0d s=%0d want t=2 s=7",
               throw_num, score);
    end
  endtask

  task automatic test_clamp();
    int n, a, b;
    do_reset();
    throw_run(4'd15, n, a, b);
    checks++;
    if (n !== 10 || a !== 0 || b !== 21) begin
      errors++;
      $display("FAIL clamp_pulses: got n=%0d adj=%0d busy=%0d want 10 0 21",
               n, a, b);
    end
    checks++;
    if (score !== 10 || throw_num !== 2'd1) begin
      errors++;
      $display("FAIL clamp_score: got s=%0d t=%0d want 10 1", score, throw_num);
    end
  endtask

  task automatic test_game();
    int n, a, b, tot;
    do_reset();
    tot = 0;
    for (int i = 0; i < 3; i++) begin
      throw_run(4'd10, n, a, b);
      tot += n;
      checks++;
      if (game_over !== (i == 2)) begin
        errors++;
        $display("FAIL game_over_throw%0d: got %b want %b", i, game_over, i == 2);
      end
    end
    checks++;
    if (tot !== 30 || throw_num !== 2'd3 || pins_ready !== 1'b0) begin
      errors++;
      $display("FAIL game_end: got p=%0d t=%0d r=%b want 30 3 0",
               tot, throw_num, pins_ready);
    end
    pins = 4'd5;
    pins_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (hit !== 1'b0 || busy !== 1'b0 || pins_ready !== 1'b0 || game_over !== 1'b1) begin
        errors++;
        $display("FAIL game_locked%0d: got h=%b b=%b r=%b g=%b want 0 0 0 1",
                 c, hit, busy, pins_ready, game_over);
      end
    end
    pins_valid = 1'b0;
    checks++;
    if (score / 10 !== 3 || score % 10 !== 0 || throw_num !== 2'd3) begin
      errors++;
      $display("FAIL game_score: got %0d t=%0d want 30 3", score, throw_num);
    end
  endtask

  task automatic test_back_to_back();
    int n, cyc;
    do_reset();
    pins = 4'd3;
    pins_valid = 1'b1;
    step();
    pins = 4'd8;
    n = 0;
    cyc = 0;
    while (busy && cyc < 40) begin
      if (hit) n++;
      cyc++;
      step();
    end
    checks++;
    if (n !== 3 || throw_num !== 2'd1 || pins_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_first: got p=%0d t=%0d r=%b want 3 1 1",
               n, throw_num, pins_ready);
    end
    step();
    pins_valid = 1'b0;
    n = 0;
    cyc = 0;
    while (busy && cyc < 40) begin
      if (hit) n++;
      cyc++;
      step();
    end
    checks++;
    if (n !== 8 || throw_num !== 2'd2 || score !== 11) begin
      errors++;
      $display("FAIL hold_second: got p=%0d t=%0d s=%0d want 8 2 11",
               n, throw_num, score);
    end
  endtask

  task automatic test_reset_mid();
    int n, a, b, cyc;
    do_reset();
    pins = 4'd9;
    pins_valid = 1'b1;
    step();
    pins_valid = 1'b0;
    n = 0;
    cyc = 0;
    while (n < 4 && cyc < 40) begin
      if (hit) n++;
      cyc++;
      if (n < 4) step();
    end
    checks++;
    if (n !== 4 || hit !== 1'b1) begin
      errors++;
      $display("FAIL mid_fourth: got p=%0d h=%b want 4 1", n, hit);
    end
    reset = 1'b1;
    pins = 4'd6;
    pins_valid = 1'b1;
    step();
    checks++;
    if (hit !== 1'b0 || busy !== 1'b0 || throw_num !== 2'd0 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL mid_abort: got h=%b b=%b t=%0d g=%b want 0 0 0 0",
               hit, busy, throw_num, game_over);
    end
    step();
    reset = 1'b0;
    pins_valid = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || hit !== 1'b0 || pins_ready !== 1'b1 || score !== 0) begin
      errors++;
      $display("FAIL mid_restart: got b=%b h=%b r=%b s=%0d want 0 0 1 0",
               busy, hit, pins_ready, score);
    end
    throw_run(4'd2, n, a, b);
    checks++;
    if (n !== 2 || b !== 5 || throw_num !== 2'd1 || score !== 2) begin
      errors++;
      $display("FAIL mid_after: got p=%0d b=%0d t=%0d s=%0d want 2 5 1 2",
               n, b, throw_num, score);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    pins_valid = 1'b0;
    pins = 4'd0;
    test_reset();
    test_seven();
    test_zero();
    test_clamp();
    test_game();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/throw_hit_sequencer.md
Name: throw_hit_sequencer

Overview:
- Producer end of the `hit` interface consumed by the score counter.
- Accepts one throw result (pins knocked, 0..10) from game logic over a valid/ready handshake.
- Serialises that count into discrete one-cycle `hit` pulses, spaced so each pulse increments the counter exactly once.
- Tracks throws per game and raises `game_over` after the last throw; total pulses per game never exceed 30 (10 x 3), which fits the counter's 5-bit score.

Parameters:
- MAX_PINS, 10, clamp ceiling for a single throw's pin count.
- MAX_THROWS, 3, throws per game before game_over.
- GAP_CYCLES, 1, low cycles forced after each hit pulse (legal range 1..15).

Ports:
- CLOCK_50  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- pins_valid  input  1  throw result offered.
- pins  input  4  pins knocked this throw; values above MAX_PINS are clamped to MAX_PINS.
- pins_ready  output  1  sequencer can accept a throw.
- hit  output  1  registered one-cycle pulse, one per pin, to the score counter's `hit` input.
- throw_num  output  2  throws completed this game (0..MAX_THROWS).
- busy  output  1  high while a throw is being serialised.
- game_over  output  1  sticky; set when throw_num reaches MAX_THROWS.

Behaviour:
- Reset (synchronous, sampled on the CLOCK_50 edge):
  - State goes to IDLE.
  - hit=0, busy=0, throw_num=0, game_over=0, remaining count=0, gap timer=0.
  - pins_ready=1 from the cycle after reset deasserts.
- All outputs are registered except pins_ready, which is combinational: `pins_ready = (state==IDLE) && !game_over`.
- A throw is accepted on the edge where `pins_valid && pins_ready`:
  - Latch `remaining = min(pins, MAX_PINS)`.
  - busy goes high the next cycle.
- States:
  - IDLE: wait for acceptance. remaining>0 -> EMIT; remaining==0 -> DONE.
  - EMIT: hit=1 for exactly one cycle; remaining decrements; load gap timer with GAP_CYCLES; go to GAP.
  - GAP: hit=0; the timer counts down. When it expires, remaining>0 -> EMIT, else -> DONE.
  - DONE: one cycle with busy=1 and hit=0.
    - On exit, throw_num increments.
    - If the new throw_num == MAX_THROWS, game_over is set.
    - Return to IDLE.
- Timing with GAP_CYCLES=1, acceptance at edge t0:
  - Pulse k is high in cycle t0+2k-1, for k=1..N.
  - DONE occupies cycle t0+2N+1.
  - pins_ready and the updated throw_num are visible at cycle t0+2N+2.
- Zero-pin throw: no hit pulses; DONE in cycle t0+1; throw still counted.
- hit is never high on two consecutive cycles.
- pins_valid is ignored while busy or game_over; no queuing.
- game_over is sticky until reset. While set, pins_ready=0 and no hit is ever produced.
- throw_num saturates at MAX_THROWS and never wraps.
- Reset mid-throw:
  - Emission aborts; hit=0 from the cycle after the reset edge.
  - The partial throw is discarded and throw_num is cleared.
  - The downstream counter shares reset, so score and sequencer restart together.
- Reset asserted together with pins_valid: reset wins and the throw is not accepted.

Decomposition:
- Shared package `bowling_pkg`:
  - State encoding constants IDLE/EMIT/GAP/DONE.
  - MAX_PINS=10, MAX_THROWS=3, MAX_SCORE=30.
  - SCORE_W=5, PINS_W=4.
  - The score counter uses the same constants.
- One natural sub-module: `gap_timer`.
  - Loadable down-counter with a done flag.
  - Synchronous active-high reset on CLOCK_50.
- FSM, clamp and throw bookkeeping stay in the top.

Test Plan:
- Reset, then pins=7 accepted at t0 (GAP=1) -> hit high at t0+1,3,...,13 (7 pulses, never adjacent); busy high t0+1..t0+15; throw_num=1 and pins_ready=1 at t0+16; attached counter reads 7.
- pins=0 -> no hit; DONE at t0+1; throw_num increments by 1; pins_ready back at t0+2.
- pins=15 (out of range) -> clamped to exactly 10 pulses; counter reads 10.
- Three throws of 10 -> 30 pulses total; game_over=1 after the third DONE; pins_valid=1 afterwards gives pins_ready=0 and no hit; counter shows 30 (tens digit 3, ones digit 0).
- pins_valid held high while busy with a new pins value -> ignored until IDLE; only the first throw's count is emitted.
- reset asserted after the 4th pulse of pins=9 -> hit=0 from the next cycle; throw_num=0, game_over=0, pins_ready=1; a following pins=2 produces exactly 2 pulses.
